uart_rx_to_axi_stream: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_to_axi_stream_if.sv | 14 +
 rtl/uart_sync_2ff.sv | 21 ++
 rtl/uart_rx_to_axi_stream.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART link definitions so the TX and RX ends agree on packet format.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DEF_CLOCKS_PER_PULSE = 4;
    localparam int unsigned DEF_BITS_PER_WORD    = 8;
    // Start bit plus stop bits on top of the data bits.
    localparam int unsigned PACKET_OVERHEAD      = 5;
    localparam int unsigned DEF_PACKET_SIZE      = DEF_BITS_PER_WORD + PACKET_OVERHEAD;

endpackage

// File: rtl/uart_rx_to_axi_stream_if.sv
// AXI-Stream beat carrying one complete multi-word UART transaction.
interface uart_rx_to_axi_stream_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = 2,
    parameter int unsigned BITS_PER_WORD = DEF_BITS_PER_WORD
);
    logic                                    m_valid;
    logic                                    m_ready;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser with a selectable reset value.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_to_axi_stream.sv
// UART receiver: collects NUM_WORDS packets from the serial line and presents the
// complete transaction as a single AXI-Stream beat, word 0 in the low lane.
module uart_rx_to_axi_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int unsigned W_OUT            = 16,
    parameter int unsigned BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int unsigned PACKET_SIZE      = BITS_PER_WORD + PACKET_OVERHEAD
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           rx,
    uart_rx_to_axi_stream_if.master        m_axis,
    output logic                           frame_err,
    output logic                           overflow
);
    localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int unsigned END_BITS  = PACKET_SIZE - BITS_PER_WORD - 1;
    localparam int unsigned HALF      = CLOCKS_PER_PULSE / 2;
    localparam int unsigned CW        = $clog2(CLOCKS_PER_PULSE);
    localparam int unsigned BW        = $clog2(PACKET_SIZE);
    localparam int unsigned WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] words_t;

    logic                     rx_s, rx_prev;
    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            c_clocks_q, c_clocks_d;
    logic [BW-1:0]            c_bits_q, c_bits_d;
    logic [WW-1:0]            c_words_q, c_words_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    words_t                   words_q, words_d;
    logic                     done, bad_stop;
    logic                     m_valid_q;
    words_t                   m_data_q;

    uart_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rx_s)
    );

    always_comb begin
        state_d    = state_q;
        c_clocks_d = c_clocks_q + CW'(1);
        c_bits_d   = c_bits_q;
        c_words_d  = c_words_q;
        shift_d    = shift_q;
        words_d    = words_q;
        done       = 1'b0;
        bad_stop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                c_clocks_d = '0;
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                if (c_clocks_q == CW'(HALF - 1)) begin
                    c_clocks_d = '0;
                    c_bits_d   = '0;
                    state_d    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (c_clocks_q == CW'(CLOCKS_PER_PULSE - 1)) begin
                    c_clocks_d = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d    = {rx_s, shift_q[BITS_PER_WORD-1:1]};
                    if (c_bits_q == BW'(BITS_PER_WORD - 1)) begin
                        c_bits_d = '0;
                        state_d  = STOP;
                    end else begin
                        c_bits_d = c_bits_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (c_clocks_q == CW'(CLOCKS_PER_PULSE - 1)) begin
                    c_clocks_d = '0;
                    if (!rx_s) begin
                        bad_stop  = 1'b1;
                        c_bits_d  = '0;
                        c_words_d = '0;
                        state_d   = IDLE;
                    end else if (c_bits_q == BW'(END_BITS - 1)) begin
                        c_bits_d           = '0;
                        state_d            = IDLE;
                        words_d[c_words_q] = shift_q;
                        if (c_words_q == WW'(NUM_WORDS - 1)) begin
                            done      = 1'b1;
                            c_words_d = '0;
                        end else begin
                            c_words_d = c_words_q + WW'(1);
                        end
                    end else begin
                        c_bits_d = c_bits_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_prev    <= 1'b1;
            state_q    <= IDLE;
            c_clocks_q <= '0;
            c_bits_q   <= '0;
            c_words_q  <= '0;
            shift_q    <= '0;
            words_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rx_prev    <= rx_s;
            state_q    <= state_d;
            c_clocks_q <= c_clocks_d;
            c_bits_q   <= c_bits_d;
            c_words_q  <= c_words_d;
            shift_q    <= shift_d;
            words_q    <= words_d;
            frame_err  <= bad_stop;
            overflow   <= 1'b0;
            if (done) begin
                // A beat still waiting on the sink wins; the new one is dropped.
                if (!m_valid_q || m_axis.m_ready) begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= words_d;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (m_valid_q && m_axis.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis.m_valid = m_valid_q;
    assign m_axis.m_data  = m_data_q;
endmodule
